// File: rtl/seg7_scan_disp.sv
// -----------------------------------------------------------------------------
// seg7_scan_disp
//
// Time-multiplexed driver for an 8-digit, common-anode seven-segment display.
// Each digit is enabled for SCAN_DIV clock cycles in turn (digit 0 first).
// One pass over all eight digits is a "frame".
//
// A new 32-bit value (8 hex digits) is captured into a pending shadow register
// whenever load is high. It is promoted to the displayed register only at a
// frame boundary, so a frame never mixes digits from two different values.
// Decimal points and blink enables are sampled live for the digit currently
// being driven. Blinking alternates every BLINK_FRAMES frames.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   disp_num    in  32   value to display, digit i = disp_num[4i+3:4i]
//   load        in   1   capture disp_num into the pending register
//   point       in   8   decimal-point enable per digit (live)
//   le          in   8   blink enable per digit (live)
//   an          out  8   active-low digit enables, an[i] selects digit i
//   seg         out  8   active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done  out  1   one-cycle pulse after the last digit of each frame
// -----------------------------------------------------------------------------
module seg7_scan_disp #(
  parameter int unsigned SCAN_DIV     = 100000,  // 2 .. 2**20
  parameter int unsigned BLINK_FRAMES = 64       // 1 .. 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_num,
  input  logic        load,
  input  logic [7:0]  point,
  input  logic [7:0]  le,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned      DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // Hex digit to segment pattern, active low, dp bit returned as 1 (off).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Scan state
  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_blink_frm;
  logic             r_blink_ph;

  // Shadow registers
  logic [31:0]      r_pending;
  logic             r_pend_valid;
  logic [31:0]      r_shown;

  // Registered outputs
  logic [7:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_frame_done;

  // Combinational helpers
  logic             w_tick;
  logic             w_frame_end;
  logic [3:0]       w_nibble;
  logic [7:0]       w_hex;
  logic [7:0]       w_an_nxt;
  logic [7:0]       w_seg_nxt;

  // The tick is the last cycle of a digit; the frame ends on the tick of digit 7.
  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_tick && (r_idx == 3'd7);

  // Per-digit dwell counter and digit index; both wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= 3'd0;
    end else if (w_tick) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_idx     <= r_idx;
    end
  end

  // Frame counter for the blink half-period; phase toggles when it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_frm <= 8'd0;
      r_blink_ph  <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_frm == BLINK_LAST) begin
        r_blink_frm <= 8'd0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_frm <= r_blink_frm + 8'd1;
        r_blink_ph  <= r_blink_ph;
      end
    end else begin
      r_blink_frm <= r_blink_frm;
      r_blink_ph  <= r_blink_ph;
    end
  end

  // Pending capture. A load on the boundary cycle wins over the clear, so the
  // new value survives for the following boundary while the old one transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 32'd0;
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pending    <= disp_num;
      r_pend_valid <= 1'b1;
    end else if (w_frame_end) begin
      r_pending    <= r_pending;
      r_pend_valid <= 1'b0;
    end else begin
      r_pending    <= r_pending;
      r_pend_valid <= r_pend_valid;
    end
  end

  // Displayed value only changes at a frame boundary, from the pre-edge pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shown <= 32'd0;
    end else if (w_frame_end && r_pend_valid) begin
      r_shown <= r_pending;
    end else begin
      r_shown <= r_shown;
    end
  end

  // Next output values for the digit currently selected by r_idx.
  always_comb begin
    w_nibble  = r_shown[{r_idx, 2'b00} +: 4];
    w_hex     = hex_to_seg(w_nibble);
    w_an_nxt  = ~(8'b0000_0001 << r_idx);
    w_seg_nxt = 8'hFF;
    if (r_blink_ph && le[r_idx]) begin
      w_seg_nxt = 8'hFF;
    end else begin
      w_seg_nxt = {~point[r_idx], w_hex[6:0]};
    end
  end

  // Output registers: one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  seg7_scan_disp_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (r_an),
    .frame_done (r_frame_done)
  );

endmodule

// -----------------------------------------------------------------------------
// seg7_scan_disp_chk
//
// Property checker for the scan outputs; contains no design logic.
//
// Ports
//   clk         in   1   clock
//   rst_n       in   1   asynchronous active-low reset
//   an          in   8   digit enables being checked
//   frame_done  in   1   frame pulse being checked
// -----------------------------------------------------------------------------
module seg7_scan_disp_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] an,
  input logic       frame_done
);

  // Once any digit is driven, exactly one digit is driven.
  a_an_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (an != 8'hFF) |-> $onehot(~an));

  // The frame pulse is a single cycle wide.
  a_fd_single: assert property (@(posedge clk) disable iff (!rst_n)
    frame_done |=> !frame_done);

endmodule

// File: tb/tb_seg7_scan_disp.sv
module tb_seg7_scan_disp;

  localparam int SD = 4;        // clocks per digit
  localparam int BF = 2;        // frames per blink half-period
  localparam int FR = SD * 8;   // clocks per frame

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] disp_num = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  point = 8'd0;
  logic [7:0]  le = 8'd0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int pcount = 0;   // clock edges seen since reset release

  // A load becomes visible from frame 'eff' onwards.
  typedef struct {
    int          eff;
    logic [31:0] val;
  } ld_t;
  ld_t lq[$];

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_disp #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_num   (disp_num),
    .load       (load),
    .point      (point),
    .le         (le),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, pcount);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, pcount);
    end
  endtask

  // Value on display during frame f: the latest load already effective.
  function automatic logic [31:0] model_shown(input int f);
    logic [31:0] v;
    v = 32'd0;
    foreach (lq[i]) begin
      if (lq[i].eff <= f) v = lq[i].val;
    end
    return v;
  endfunction

  // One clock: predict outputs from elapsed time and inputs, then compare.
  task automatic step();
    int          p, idx, f;
    logic [31:0] sh;
    logic [3:0]  nib;
    logic [7:0]  e_an, e_seg;
    logic        e_fd;
    ld_t         e;
    p   = pcount;
    idx = (p / SD) % 8;
    f   = p / FR;
    sh  = model_shown(f);
    nib = sh[idx*4 +: 4];
    e_an = ~(8'b1 << idx);
    if (((f / BF) % 2 == 1) && le[idx]) begin
      e_seg = 8'hFF;
    end else begin
      e_seg = hex_tbl[nib];
      e_seg[7] = ~point[idx];
    end
    e_fd = ((p % FR) == FR - 1);
    if (load) begin
      // A load on the last cycle of a frame misses that boundary.
      e.eff = ((p % FR) == FR - 1) ? f + 2 : f + 1;
      e.val = disp_num;
      lq.push_back(e);
    end
    @(posedge clk);
    #1;
    pcount++;
    check8("an", an, e_an);
    check8("seg", seg, e_seg);
    check1("frame_done", frame_done, e_fd);
  endtask

  // Advance until the next edge falls at in-frame position ph.
  task automatic run_to(input int ph);
    int guard;
    guard = 0;
    while (((pcount % FR) != ph) && (guard < 2 * FR)) begin
      step();
      guard++;
    end
  endtask

  task automatic pulse_load(input logic [31:0] v);
    disp_num = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check8("rst_an", an, 8'hFF);
    check8("rst_seg", seg, 8'hFF);
    check1("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    pcount = 0;

    // Plain scan with all inputs low, a little past one frame
    repeat (40) step();

    // Load in the middle of digit 3
    run_to(13);
    pulse_load(32'h89ABCDEF);
    repeat (2 * FR) step();

    // Two back-to-back loads in one frame: only the second is shown
    run_to(6);
    pulse_load(32'h11111111);
    pulse_load(32'h22222222);
    repeat (2 * FR) step();

    // Load on the boundary cycle while an older load is still pending
    run_to(5);
    pulse_load(32'h01234567);
    run_to(FR - 1);
    pulse_load(32'hFEDCBA98);
    repeat (3 * FR) step();

    // Decimal point on digit 0, blink on digit 7, across eight frames
    point = 8'h01;
    le = 8'h80;
    repeat (8 * FR) step();

    // Randomized inputs
    for (int i = 0; i < 640; i++) begin
      point = 8'($urandom);
      le = 8'($urandom);
      disp_num = $urandom;
      load = ($urandom_range(0, 11) == 0);
      step();
    end
    load = 1'b0;
    point = 8'h00;
    le = 8'h00;

    // Asynchronous reset mid-digit-5 with a pending load
    run_to(13);
    pulse_load(32'h5A5A5A5A);
    run_to(21);
    rst_n = 1'b0;
    #1;
    check8("async_an", an, 8'hFF);
    check8("async_seg", seg, 8'hFF);
    check1("async_fd", frame_done, 1'b0);
    #2;
    rst_n = 1'b1;
    pcount = 0;
    lq.delete();
    repeat (2 * FR) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_disp.md
SEG7_SCAN_DISP -- requirements
Module: seg7_scan_disp

Interface
REQ-001 The block SHALL provide parameter SCAN_DIV, default 100000, giving the number of clk cycles each digit is driven (legal range 2..2^20).
REQ-002 The block SHALL provide parameter BLINK_FRAMES, default 64, giving the number of full frames per blink half-period (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port disp_num, input, 32, the value to display (8 hex digits); it is driven by the upstream 8:1 32-bit selector.
REQ-006 The block SHALL have port load, input, 1, a request to capture disp_num.
REQ-007 The block SHALL have port point, input, 8, the decimal-point enable per digit, sampled live.
REQ-008 The block SHALL have port le, input, 8, the blink enable per digit, sampled live.
REQ-009 The block SHALL have port an, output, 8, active-low digit enables; an[i] selects digit i.
REQ-010 The block SHALL have port seg, output, 8, active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse at the end of each frame.

Function
REQ-012 Divider: div_cnt counts 0..SCAN_DIV-1, then wraps to 0; the wrap cycle is the "tick".
REQ-013 Digit index: idx (3 bits) increments by 1 on each tick, and 7 wraps to 0.
REQ-014 Shadow registers: pending (32 bits) plus pend_valid, and shown (32 bits).
- load=1 writes disp_num into pending and sets pend_valid.
- Back-to-back loads keep only the last value.
REQ-015 Frame boundary: on a tick with idx=7, if pend_valid, then shown <= pending and pend_valid clears.
- A load in that same cycle sets pend_valid with the new value, which is shown on the next frame boundary.
- The tick transfers the old pending value.
REQ-016 Digit i SHALL display shown[4i+3:4i] in hex: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values are seg[6:0] with dp=1).
REQ-017 seg[7] SHALL be ~point[idx].
REQ-018 Blink:
- blink_frm counts frames 0..BLINK_FRAMES-1.
- At its wrap, blink_ph toggles.
- When blink_ph=1 and le[idx]=1, seg SHALL be 8'hFF while an is still driven normally.
REQ-019 Outputs an, seg, and frame_done SHALL be registered, with exactly 1 cycle latency from idx/div state; an SHALL be ~(8'b1 << idx).
REQ-020 Exactly one bit of an SHALL be low in every cycle after the first post-reset cycle.
REQ-021 frame_done SHALL be high for exactly the one cycle following the tick where idx went from 7 to 0.
REQ-022 All counters SHALL wrap silently, and no input combination SHALL stall scanning.

Reset
REQ-023 When rst_n=0, the block SHALL immediately (asynchronously) force these values:
- div_cnt=0, idx=0, blink_frm=0, blink_ph=0
- pending=0, pend_valid=0, shown=0
- an=8'hFF, seg=8'hFF, frame_done=0
REQ-024 After rst_n deasserts, the first clk edge SHALL drive an=8'hFE and seg=8'hC0 (digit 0, value 0, dp off).
REQ-025 Reset asserted mid-frame SHALL discard any pending load, and the display restarts at digit 0.

Verification (bench uses SCAN_DIV=4, BLINK_FRAMES=2)
REQ-026 Scenario: reset release with all inputs 0 -> an=FE, seg=C0 for 4 cycles, then an steps FD, FB, ... 7F, 4 cycles each; frame_done pulses once after 32 cycles.
REQ-027 Scenario: load=1 with disp_num=32'h89ABCDEF in the middle of digit 3 -> digits 4..7 still show 0; the next frame shows F, E, d, C, b, A, 9, 8, i.e. seg 8E, 86, A1, C6, 83, 88, 90, 80.
REQ-028 Scenario: load value 32'h11111111, then load 32'h22222222 one cycle later, both within the same frame -> the next frame shows only A4 on all digits; 1 is never displayed.
REQ-029 Scenario: load asserted on the idx=7 tick cycle -> the old pending value appears at the boundary, and the new value appears one frame later.
REQ-030 Scenario: point=8'h01, le=8'h80 -> seg[7]=0 on digit 0 only; digit 7 shows FF during frames 2-3 and 6-7, normal otherwise, and an is unaffected.
REQ-031 Scenario: rst_n pulsed low for 3 ns mid-digit-5 -> outputs go to FF/FF/0 immediately with no clock edge; the restart matches REQ-024.
